// File: rtl/fma16_pkg.sv
// fma16_pkg
// Shared types and constants for the fp16 FMA back-end stages.
//   fp16_t    : raw IEEE-754 binary16 word
//   fflags_t  : exception flags {nv, of, uf, nx}, packed MSB-first
//   occ_t     : occupancy encoding of the 2-entry result skid buffer
//   canonNan(): maps any NaN encoding onto the canonical quiet NaN
package fma16_pkg;

    typedef logic [15:0] fp16_t;

    typedef struct packed {
        logic nv;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam fp16_t FP16_QNAN  = 16'h7e00;
    localparam fp16_t FP16_INF_P = 16'h7c00;
    localparam fp16_t FP16_INF_N = 16'hfc00;

    localparam int NV_B = 3;
    localparam int OF_B = 2;
    localparam int UF_B = 1;
    localparam int NX_B = 0;

    // Buffer occupancy; the 2'd3 encoding is unused and treated as empty.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    // Exponent all-ones with a nonzero mantissa is a NaN of either sign.
    function automatic logic isNan(input fp16_t v);
        return (v[14:10] == 5'h1f) && (v[9:0] != 10'h000);
    endfunction

    // Replace any NaN (signalling, quiet, negative, payload-carrying) by 7e00.
    function automatic fp16_t canonNan(input fp16_t v);
        fp16_t r;
        if (isNan(v)) begin
            r = FP16_QNAN;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/fma16_skid_buf.sv
// fma16_skid_buf
// Generic 2-entry valid/ready buffer. Head entry drives outData directly
// from a register; the second entry waits in tailR while the head is stalled.
// inReady and outValid are registered so neither handshake side sees a
// combinational path from the other.
//   clk, rst          : clock, asynchronous active-high reset
//   inValid/inReady   : upstream handshake, inData payload
//   outValid/outReady : downstream handshake, outData payload (head entry)
import fma16_pkg::*;

module fma16_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inValid,
    output logic         inReady,
    input  logic [W-1:0] inData,
    output logic         outValid,
    input  logic         outReady,
    output logic [W-1:0] outData
);

    occ_t         occR;
    occ_t         nextOccS;
    logic         validR;
    logic         readyR;
    logic [W-1:0] headR;
    logic [W-1:0] tailR;
    logic         pushS;
    logic         popS;
    logic         headFromInS;
    logic         headFromTailS;
    logic         tailFromInS;

    assign pushS    = inValid & readyR;
    assign popS     = validR & outReady;
    assign inReady  = readyR;
    assign outValid = validR;
    assign outData  = headR;

    // Occupancy state register plus registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occR   <= OCC_EMPTY;
            validR <= 1'b0;
            readyR <= 1'b1;
        end else begin
            occR   <= nextOccS;
            validR <= (nextOccS != OCC_EMPTY);
            readyR <= (nextOccS != OCC_FULL);
        end
    end

    // Next occupancy and storage steering.
    always_comb begin
        nextOccS      = occR;
        headFromInS   = 1'b0;
        headFromTailS = 1'b0;
        tailFromInS   = 1'b0;
        case (occR)
            OCC_EMPTY: begin
                if (pushS) begin
                    nextOccS    = OCC_ONE;
                    headFromInS = 1'b1;
                end else begin
                    nextOccS = OCC_EMPTY;
                end
            end
            OCC_ONE: begin
                if (pushS && popS) begin
                    // Head leaves this cycle, new entry replaces it directly.
                    nextOccS    = OCC_ONE;
                    headFromInS = 1'b1;
                end else if (pushS) begin
                    nextOccS    = OCC_FULL;
                    tailFromInS = 1'b1;
                end else if (popS) begin
                    nextOccS = OCC_EMPTY;
                end else begin
                    nextOccS = OCC_ONE;
                end
            end
            OCC_FULL: begin
                if (popS) begin
                    nextOccS      = OCC_ONE;
                    headFromTailS = 1'b1;
                end else begin
                    nextOccS = OCC_FULL;
                end
            end
            default: begin
                // Illegal encoding behaves exactly like EMPTY.
                if (pushS) begin
                    nextOccS    = OCC_ONE;
                    headFromInS = 1'b1;
                end else begin
                    nextOccS = OCC_EMPTY;
                end
            end
        endcase
    end

    // Head and tail payload storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headR <= {W{1'b0}};
            tailR <= {W{1'b0}};
        end else begin
            if (headFromInS) begin
                headR <= inData;
            end else if (headFromTailS) begin
                headR <= tailR;
            end else begin
                headR <= headR;
            end
            if (tailFromInS) begin
                tailR <= inData;
            end else begin
                tailR <= tailR;
            end
        end
    end

    fma16_skid_buf_chk #(.W(W)) uChk (
        .clk      (clk),
        .rst      (rst),
        .occ      (occR),
        .outValid (validR),
        .outReady (outReady),
        .outData  (headR)
    );

endmodule

// fma16_skid_buf_chk
// Properties of the skid buffer: occupancy never reaches the unused
// encoding, and a stalled head entry holds its payload.
module fma16_skid_buf_chk #(
    parameter int W = 8
) (
    input logic         clk,
    input logic         rst,
    input logic [1:0]   occ,
    input logic         outValid,
    input logic         outReady,
    input logic [W-1:0] outData
);

    // Occupancy must stay within EMPTY/ONE/FULL.
    always @(posedge clk) begin
        if (!rst) begin
            assert (occ != 2'd3)
                else $error("skid buffer occupancy reached illegal encoding");
        end
    end

    // A stalled valid head keeps its payload.
    property pStallHold;
        @(posedge clk) disable iff (rst)
            (outValid && !outReady) |=> (outValid && $stable(outData));
    endproperty
    aStallHold: assert property (pStallHold)
        else $error("skid buffer head changed while stalled");

endmodule

// File: rtl/fma16_result_stage.sv
// fma16_result_stage
// Output stage behind the fp16 special-case/flag resolver. Each resolved
// result travels with its {NV,OF,UF,NX} flags, special-case marker and tag
// through a 2-entry skid buffer to the consumer. Delivered entries accrue
// into sticky fflags and bump a saturating done_cnt.
// Build option: define FMA16_CANON_NAN_EN to replace every NaN result with
// the canonical quiet NaN 16'h7e00 on entry; otherwise NaNs pass bit-exact.
//   clk, reset        : clock, asynchronous active-high reset
//   in_*              : upstream valid/ready handshake and payload
//   out_*             : head entry with valid/ready handshake
//   fflags/fflags_clr : sticky accrued flags and their synchronous clear
//   done_cnt          : saturating count of delivered results
import fma16_pkg::*;

module fma16_result_stage #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_result,
    input  logic [3:0]       in_flags,
    input  logic             in_special,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [3:0]       out_flags,
    output logic             out_special,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       fflags,
    input  logic             fflags_clr,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int PW = 16 + 4 + 1 + TAG_W;

    fp16_t            storeResultS;
    logic [PW-1:0]    bufInS;
    logic [PW-1:0]    bufOutS;
    logic             popS;
    fflags_t          fflagsR;
    fflags_t          headFlagsS;
    logic [CNT_W-1:0] doneCntR;

`ifdef FMA16_CANON_NAN_EN
    assign storeResultS = canonNan(in_result);
`else
    assign storeResultS = in_result;
`endif

    // Payload layout: {special, tag, flags, result}.
    assign bufInS = {in_special, in_tag, in_flags, storeResultS};

    fma16_skid_buf #(.W(PW)) uBuf (
        .clk      (clk),
        .rst      (reset),
        .inValid  (in_valid),
        .inReady  (in_ready),
        .inData   (bufInS),
        .outValid (out_valid),
        .outReady (out_ready),
        .outData  (bufOutS)
    );

    assign out_result  = bufOutS[15:0];
    assign out_flags   = bufOutS[19:16];
    assign out_tag     = bufOutS[20 +: TAG_W];
    assign out_special = bufOutS[PW-1];

    assign popS       = out_valid & out_ready;
    assign headFlagsS = fflags_t'(bufOutS[19:16]);
    assign fflags     = fflagsR;
    assign done_cnt   = doneCntR;

    // Sticky flags: a clear coinciding with a pop keeps only the popped flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fflagsR <= fflags_t'(4'b0000);
        end else if (popS && fflags_clr) begin
            fflagsR <= headFlagsS;
        end else if (popS) begin
            fflagsR <= fflagsR | headFlagsS;
        end else if (fflags_clr) begin
            fflagsR <= fflags_t'(4'b0000);
        end else begin
            fflagsR <= fflagsR;
        end
    end

    // Delivered-result counter, holding at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            doneCntR <= {CNT_W{1'b0}};
        end else if (popS && (doneCntR != {CNT_W{1'b1}})) begin
            doneCntR <= doneCntR + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            doneCntR <= doneCntR;
        end
    end

endmodule

// File: tb/tb_fma16_result_stage.sv
module tb_fma16_result_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [3:0]  in_flags;
    logic        in_special;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_flags;
    logic        out_special;
    logic [3:0]  out_tag;
    logic [3:0]  fflags;
    logic        fflags_clr;
    logic [15:0] done_cnt;

    int checks = 0;
    int failures = 0;

    fma16_result_stage #(.TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_flags(in_flags), .in_special(in_special), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_special(out_special), .out_tag(out_tag),
        .fflags(fflags), .fflags_clr(fflags_clr), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        logic        spc;
        logic [3:0]  tag;
        logic [15:0] expRaw;
        logic [15:0] expCanon;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] r, input logic [3:0] f, input logic s, input logic [3:0] t);
        in_valid   = 1'b1;
        in_result  = r;
        in_flags   = f;
        in_special = s;
        in_tag     = t;
    endtask

    function automatic logic [15:0] pickRes(input vec_t v);
`ifdef FMA16_CANON_NAN_EN
        return v.expCanon;
`else
        return v.expRaw;
`endif
    endfunction

    initial begin
        logic [3:0]  accFlags;
        logic [15:0] expCnt;

        vecs[0] = '{16'h3c00, 4'b0000, 1'b0, 4'd1, 16'h3c00, 16'h3c00};
        vecs[1] = '{16'h7c00, 4'b0101, 1'b1, 4'd2, 16'h7c00, 16'h7c00};
        vecs[2] = '{16'h3c01, 4'b0001, 1'b0, 4'd3, 16'h3c01, 16'h3c01};
        vecs[3] = '{16'hfe01, 4'b1000, 1'b1, 4'd4, 16'hfe01, 16'h7e00};
        vecs[4] = '{16'h7e00, 4'b1000, 1'b1, 4'd5, 16'h7e00, 16'h7e00};
        vecs[5] = '{16'h0001, 4'b0011, 1'b0, 4'd6, 16'h0001, 16'h0001};
        vecs[6] = '{16'hfc00, 4'b0100, 1'b1, 4'd7, 16'hfc00, 16'hfc00};
        vecs[7] = '{16'h7c01, 4'b1000, 1'b1, 4'd8, 16'h7c01, 16'h7e00};

        reset = 1'b1; in_valid = 1'b0; in_result = 16'h0000; in_flags = 4'b0000;
        in_special = 1'b0; in_tag = 4'd0; out_ready = 1'b0; fflags_clr = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_fflags", 32'(fflags), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Table: single entries through an empty buffer with out_ready high.
        accFlags = 4'b0000;
        expCnt   = 16'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].res, vecs[i].flg, vecs[i].spc, vecs[i].tag);
            step();
            in_valid = 1'b0;
            check("vec_out_valid", 32'(out_valid), 32'd1);
            check("vec_out_result", 32'(out_result), 32'(pickRes(vecs[i])));
            check("vec_out_flags", 32'(out_flags), 32'(vecs[i].flg));
            check("vec_out_special", 32'(out_special), 32'(vecs[i].spc));
            check("vec_out_tag", 32'(out_tag), 32'(vecs[i].tag));
            step();
            accFlags = accFlags | vecs[i].flg;
            expCnt   = expCnt + 16'd1;
            check("vec_done_cnt", 32'(done_cnt), 32'(expCnt));
            check("vec_fflags", 32'(fflags), 32'(accFlags));
            check("vec_drained", 32'(out_valid), 32'd0);
        end

        // Clear without pop.
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        check("clr_fflags", 32'(fflags), 32'd0);

        // Back-pressure: two entries fill the buffer, third is held off.
        out_ready = 1'b0;
        drive(16'h4000, 4'b0000, 1'b0, 4'd1);
        step();
        check("bp_ready1", 32'(in_ready), 32'd1);
        drive(16'h4200, 4'b0000, 1'b0, 4'd2);
        step();
        check("bp_ready_full", 32'(in_ready), 32'd0);
        check("bp_head", 32'(out_result), 32'h4000);
        drive(16'h4400, 4'b0000, 1'b0, 4'd3);
        step();
        step();
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        check("bp_hold_head", 32'(out_result), 32'h4000);
        check("bp_hold_tag", 32'(out_tag), 32'd1);
        out_ready = 1'b1;
        step();
        check("bp_pop1_head", 32'(out_result), 32'h4200);
        check("bp_pop1_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_pop2_head", 32'(out_result), 32'h4400);
        check("bp_pop2_tag", 32'(out_tag), 32'd3);
        step();
        expCnt = expCnt + 16'd3;
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_done_cnt", 32'(done_cnt), 32'(expCnt));

        // Sticky flags accrue, then clear coinciding with a pop.
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        drive(16'h7c00, 4'b0101, 1'b1, 4'd4);
        step();
        drive(16'h3c01, 4'b0001, 1'b0, 4'd5);
        step();
        in_valid = 1'b0;
        step();
        check("sticky_accrue", 32'(fflags), 32'b0101);
        out_ready = 1'b0;
        drive(16'h7e00, 4'b1000, 1'b1, 4'd6);
        step();
        in_valid = 1'b0;
        check("sticky_head_flags", 32'(out_flags), 32'b1000);
        out_ready  = 1'b1;
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        check("sticky_clr_pop", 32'(fflags), 32'b1000);
        expCnt = expCnt + 16'd3;
        check("sticky_done_cnt", 32'(done_cnt), 32'(expCnt));

        // Streaming: push and pop every cycle.
        for (int i = 0; i < 8; i++) begin
            drive(16'h3c00 + 16'(i), 4'b0000, 1'b0, 4'(i));
            step();
            check("stream_ready", 32'(in_ready), 32'd1);
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_head", 32'(out_result), 32'h3c00 + 32'(i));
        end
        in_valid = 1'b0;
        step();
        expCnt = expCnt + 16'd8;
        check("stream_done_cnt", 32'(done_cnt), 32'(expCnt));

        // Reset in the middle of operation with a full buffer.
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        drive(16'h5000, 4'b1001, 1'b0, 4'd9);
        step();
        in_valid = 1'b0;
        step();
        check("mid_fflags_pre", 32'(fflags), 32'b1001);
        out_ready = 1'b0;
        drive(16'h5100, 4'b0000, 1'b0, 4'd10);
        step();
        drive(16'h5200, 4'b0000, 1'b0, 4'd11);
        step();
        in_valid = 1'b0;
        check("mid_full", 32'(in_ready), 32'd0);
        #3;
        reset = 1'b1;
        #1;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd1);
        check("mid_fflags", 32'(fflags), 32'd0);
        check("mid_done_cnt", 32'(done_cnt), 32'd0);
        check("mid_out_result", 32'(out_result), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_cnt", 32'(done_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fma16_result_stage.md
Name: fma16_result_stage

Overview:
- Output stage directly downstream of the fp16 special-case/flag resolver.
- Captures each resolved half-precision result with its 4-bit exception flags {NV, OF, UF, NX} and an operation tag.
- Buffers them in a 2-entry skid buffer behind a valid/ready handshake, then presents them to the consumer (testbench/writeback).
- Maintains architecturally sticky accrued flags (fflags-style), plus a transaction counter.

Parameters:
- TAG_W, 4, width of the operation tag carried alongside each result.
- CNT_W, 16, width of the completed-result counter (saturating).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream result/flags valid this cycle.
- in_ready  out  1  stage can accept; equals buffer-not-full.
- in_result  in  16  resolved fp16 result.
- in_flags  in  4  {NV, OF, UF, NX} from resolver.
- in_special  in  1  result came from a special-case path.
- in_tag  in  TAG_W  operation tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head entry.
- out_result  out  16  head result.
- out_flags  out  4  head flags.
- out_special  out  1  head special-case marker.
- out_tag  out  TAG_W  head tag.
- fflags  out  4  sticky OR of flags of all results delivered since reset/clear.
- fflags_clr  in  1  synchronous clear of fflags.
- done_cnt  out  CNT_W  count of delivered results, saturates at all-ones.

Behaviour:
- Reset (async assert, sync release):
  - buffer count = 0, out_valid = 0, in_ready = 1.
  - out_result/out_flags/out_special/out_tag = 0; fflags = 0; done_cnt = 0.
- Transfers:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready depends only on registered state, never combinationally on out_ready.
- Occupancy state machine (2-bit count), states EMPTY(0), ONE(1), FULL(2):
  - EMPTY: push -> ONE; otherwise stay. out_valid = 0.
  - ONE: push & ~pop -> FULL; ~push & pop -> EMPTY; push & pop -> ONE (new entry becomes head next cycle); neither -> stay.
  - FULL: in_ready = 0; pop -> ONE (second entry becomes head); otherwise stay.
  - Count 3 is illegal; it is treated as EMPTY and flagged by assertion.
- Latency:
  - Entry pushed at edge N is visible at out_* after edge N when the buffer was EMPTY (1-cycle latency).
  - Order is strictly FIFO.
- Outputs are driven straight from head register storage, with no combinational path from in_* to out_*. out_* hold stable while out_valid & ~out_ready.
- Data is passed unmodified: result, flags, special marker and tag are not altered. Flag bit 1 (UF) is stored and delivered as received.
- fflags:
  - On pop: fflags <= fflags | out_flags.
  - On fflags_clr without pop: fflags <= 0.
  - On fflags_clr and pop in the same cycle: fflags <= out_flags (clear, then accrue the delivered entry).
- done_cnt increments by 1 on each pop and holds at 2^CNT_W-1.
- Reset asserted mid-operation discards all buffered entries immediately. No partial delivery; fflags and done_cnt return to 0.

Optional Feature:
- Macro FMA16_CANON_NAN_EN.
- When defined: on push, any in_result with exponent 5'h1f and nonzero mantissa is replaced by canonical 16'h7e00 before storage. NV and the other flags are unchanged.
- When undefined: NaN payloads and signs pass through bit-exact.

Decomposition:
- Shared package fma16_pkg:
  - typedef fp16_t (16-bit logic).
  - typedef fflags_t (struct packed {nv, of, uf, nx}).
  - Constants FP16_QNAN = 16'h7e00, FP16_INF_P = 16'h7c00, FP16_INF_N = 16'hfc00.
  - Flag bit indices NV_B = 3, OF_B = 2, UF_B = 1, NX_B = 0.
- One sub-module, fma16_skid_buf: generic 2-entry valid/ready buffer, parameterised by payload width. The top handles canonicalisation, fflags and done_cnt.

Test Plan:
- Single pass:
  - Stimulus: out_ready = 1; push result 16'h3c00, flags 4'b0000, tag 1.
  - Required: 1 cycle later out_valid = 1, out_result = 16'h3c00, out_tag = 1; next cycle done_cnt = 1, fflags = 0.
- Back-pressure:
  - Stimulus: out_ready = 0; push 16'h4000 (tag 1), 16'h4200 (tag 2), 16'h4400 (tag 3).
  - Required: in_ready falls after the second push and the third is held. out_result stays 16'h4000.
  - Then raise out_ready: outputs 16'h4000, 16'h4200, 16'h4400 in order, one per cycle after in_ready recovers.
- Sticky flags:
  - Stimulus: deliver 16'h7c00 with flags 4'b0101 (OF, NX), then 16'h3c01 with flags 4'b0001.
  - Required: fflags = 4'b0101.
  - Then pulse fflags_clr together with a pop of an entry carrying 4'b1000: fflags = 4'b1000.
- Simultaneous push/pop in ONE:
  - Stimulus: continuous in_valid and out_ready for 8 results.
  - Required: in_ready held 1 throughout, throughput 1 result/cycle, done_cnt = 8.
- Reset mid-operation:
  - Stimulus: with FULL buffer and fflags = 4'b1001, assert reset asynchronously between edges.
  - Required: out_valid = 0, in_ready = 1, fflags = 0, done_cnt = 0 before the next edge.
- NaN canonicalisation:
  - Stimulus: push 16'hfe01 with flags 4'b1000.
  - Required: with FMA16_CANON_NAN_EN, out_result = 16'h7e00; without it, out_result = 16'hfe01. out_flags = 4'b1000 in both builds.
